// File: rtl/sram_frame_writer.sv
// sram_frame_writer
//   Packs a little-endian byte stream (low byte first) into 16-bit words and
//   writes them to an external asynchronous SRAM. Each write has a one-cycle
//   address/data setup, a WR_PULSE-cycle WE_n pulse and a one-cycle hold.
//   All bus outputs are registered, so WE_n never moves on the same edge as
//   addr or io_out.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start_n               active-low start, sampled only in IDLE
//   base_addr, n_words    frame placement and length, latched at start
//   din, din_valid        byte stream in; accepted on din_valid & din_ready
//   din_ready             high in the LO/HI byte-collection states
//   CE_n OE_n WE_n UB_n LB_n addr io_out io_oe   SRAM bus (io_oe=1 drives IO)
//   busy, done            frame in progress / one-cycle end-of-frame pulse
//
// Optional feature (macro SRAM_WR_READBACK_EN)
//   Adds io_in, err_cnt and err_addr. After each write the word is read back
//   for READ_WAIT cycles and compared; mismatches bump err_cnt (saturating)
//   and record err_addr. Without the macro OE_n is tied high.
module sram_frame_writer #(
   parameter int ADDR_W    = 20,
   parameter int WR_PULSE  = 2,
   parameter int READ_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_n,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] n_words,
   input  logic [7:0]        din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              CE_n,
   output logic              OE_n,
   output logic              WE_n,
   output logic              UB_n,
   output logic              LB_n,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       io_out,
   output logic              io_oe,
   output logic              busy,
   output logic              done
`ifdef SRAM_WR_READBACK_EN
   ,
   input  logic [15:0]       io_in,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] err_addr
`endif
);

   // Elaboration-time parameter sanity checks.
   if (WR_PULSE < 1) begin : g_bad_wr_pulse
      $error("WR_PULSE must be >= 1");
   end
   if (READ_WAIT < 1) begin : g_bad_read_wait
      $error("READ_WAIT must be >= 1");
   end

`ifdef SRAM_WR_READBACK_EN
   typedef enum logic [3:0] {
      S_IDLE, S_LO, S_HI, S_SETUP, S_PULSE, S_HOLD, S_RD, S_CMP, S_DONE
   } state_t;
   localparam logic [7:0] READ_LAST = 8'(READ_WAIT - 1);
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LO, S_HI, S_SETUP, S_PULSE, S_HOLD, S_DONE
   } state_t;
`endif

   localparam logic [7:0]        PULSE_LAST = 8'(WR_PULSE - 1);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

   state_t            state_reg;
   logic [7:0]        tmr_reg;
   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W-1:0] n_words_reg;
   logic [ADDR_W-1:0] idx_reg;
   logic              ce_n_reg, we_n_reg, lanes_n_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [15:0]       io_out_reg;
   logic              io_oe_reg, din_ready_reg, busy_reg, done_reg;
   logic              last_word;
`ifdef SRAM_WR_READBACK_EN
   logic              oe_n_reg;
   logic [15:0]       rd_data_reg;
   logic [15:0]       err_cnt_reg;
   logic [ADDR_W-1:0] err_addr_reg;
`endif

   // n_words is never zero once a word is being written, so the -1 is safe.
   assign last_word = (idx_reg == n_words_reg - ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         tmr_reg       <= '0;
         base_reg      <= '0;
         n_words_reg   <= '0;
         idx_reg       <= '0;
         ce_n_reg      <= 1'b1;
         we_n_reg      <= 1'b1;
         lanes_n_reg   <= 1'b1;
         addr_reg      <= '0;
         io_out_reg    <= '0;
         io_oe_reg     <= 1'b0;
         din_ready_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
`ifdef SRAM_WR_READBACK_EN
         oe_n_reg      <= 1'b1;
         rd_data_reg   <= '0;
         err_cnt_reg   <= '0;
         err_addr_reg  <= '0;
`endif
      end else begin
         // Word-completion step, shared by HOLD (plain build) and CMP.
         // Releasing the bus here keeps CE_n high while waiting for bytes.
         if (
`ifdef SRAM_WR_READBACK_EN
             state_reg == S_CMP
`else
             state_reg == S_HOLD
`endif
            ) begin
            ce_n_reg    <= 1'b1;
            lanes_n_reg <= 1'b1;
            io_oe_reg   <= 1'b0;
            if (last_word) begin
               state_reg <= S_DONE;
               done_reg  <= 1'b1;
            end else begin
               idx_reg       <= idx_reg + ONE;
               state_reg     <= S_LO;
               din_ready_reg <= 1'b1;
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (!start_n) begin
                  base_reg    <= base_addr;
                  n_words_reg <= n_words;
                  idx_reg     <= '0;
                  busy_reg    <= 1'b1;
`ifdef SRAM_WR_READBACK_EN
                  err_cnt_reg  <= '0;
                  err_addr_reg <= '0;
`endif
                  if (n_words == '0) begin
                     state_reg <= S_DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg     <= S_LO;
                     din_ready_reg <= 1'b1;
                  end
               end
            end
            S_LO: begin
               if (din_valid) begin
                  io_out_reg[7:0] <= din;
                  state_reg       <= S_HI;
               end
            end
            S_HI: begin
               // Address and data settle here, one edge before WE_n falls.
               if (din_valid) begin
                  io_out_reg[15:8] <= din;
                  din_ready_reg    <= 1'b0;
                  addr_reg         <= base_reg + idx_reg;
                  ce_n_reg         <= 1'b0;
                  lanes_n_reg      <= 1'b0;
                  io_oe_reg        <= 1'b1;
                  state_reg        <= S_SETUP;
               end
            end
            S_SETUP: begin
               we_n_reg  <= 1'b0;
               tmr_reg   <= '0;
               state_reg <= S_PULSE;
            end
            S_PULSE: begin
               if (tmr_reg == PULSE_LAST) begin
                  we_n_reg  <= 1'b1;
                  state_reg <= S_HOLD;
               end else begin
                  tmr_reg <= tmr_reg + 8'd1;
               end
            end
`ifdef SRAM_WR_READBACK_EN
            S_HOLD: begin
               // Turn the bus around: stop driving and enable SRAM output together.
               io_oe_reg <= 1'b0;
               oe_n_reg  <= 1'b0;
               tmr_reg   <= '0;
               state_reg <= S_RD;
            end
            S_RD: begin
               if (tmr_reg == READ_LAST) begin
                  rd_data_reg <= io_in;
                  oe_n_reg    <= 1'b1;
                  state_reg   <= S_CMP;
               end else begin
                  tmr_reg <= tmr_reg + 8'd1;
               end
            end
            S_CMP: begin
               if (rd_data_reg != io_out_reg) begin
                  if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
                  err_addr_reg <= addr_reg;
               end
            end
`else
            S_HOLD: begin
            end
`endif
            S_DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign din_ready = din_ready_reg;
   assign CE_n      = ce_n_reg;
   assign WE_n      = we_n_reg;
   assign UB_n      = lanes_n_reg;
   assign LB_n      = lanes_n_reg;
   assign addr      = addr_reg;
   assign io_out    = io_out_reg;
   assign io_oe     = io_oe_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
`ifdef SRAM_WR_READBACK_EN
   assign OE_n      = oe_n_reg;
   assign err_cnt   = err_cnt_reg;
   assign err_addr  = err_addr_reg;
`else
   assign OE_n      = 1'b1;
`endif

endmodule

// File: tb/tb_sram_frame_writer.sv
// tb_sram_frame_writer
//   Directed bench for sram_frame_writer: frame writes, zero-length frame,
//   address wrap, stalled stream, mid-pulse reset, and (with
//   SRAM_WR_READBACK_EN) readback error detection against a corrupting memory.
module tb_sram_frame_writer;
   localparam int ADDR_W    = 20;
   localparam int WR_PULSE  = 2;
   localparam int READ_WAIT = 2;
`ifdef SRAM_WR_READBACK_EN
   localparam int WORD_CYC  = 4 + WR_PULSE + READ_WAIT + 1;
`else
   localparam int WORD_CYC  = 4 + WR_PULSE;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start_n;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] n_words;
   logic [7:0]        din;
   logic              din_valid;
   logic              din_ready, CE_n, OE_n, WE_n, UB_n, LB_n, io_oe, busy, done;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       io_out;
   logic [15:0]       mem [0:15];
`ifdef SRAM_WR_READBACK_EN
   logic [15:0]       io_in;
   logic [15:0]       err_cnt;
   logic [ADDR_W-1:0] err_addr;
   assign io_in = mem[addr[3:0]];
`endif

   sram_frame_writer #(.ADDR_W(ADDR_W), .WR_PULSE(WR_PULSE), .READ_WAIT(READ_WAIT)) dut (
      .clk(clk), .rst(rst), .start_n(start_n), .base_addr(base_addr), .n_words(n_words),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .UB_n(UB_n), .LB_n(LB_n),
      .addr(addr), .io_out(io_out), .io_oe(io_oe), .busy(busy), .done(done)
`ifdef SRAM_WR_READBACK_EN
      , .io_in(io_in), .err_cnt(err_cnt), .err_addr(err_addr)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- bus monitor (samples on falling edge) ----------------
   typedef struct { logic [ADDR_W-1:0] a; logic [15:0] d; int len; } wr_t;
   wr_t wr_q[$];
   int cyc = 0, done_cnt = 0, done_cyc = 0, busy_rise_cyc = 0, first_lo_cyc = -1;
   int ce_low_cnt = 0, we_low_cnt = 0, rdy_cnt = 0, viol = 0, we_len = 0;
   int corrupt_idx = -1;
   logic prev_we = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [15:0] prev_io = '0;

   always @(negedge clk) begin
      wr_t w;
      cyc++;
      if (!rst) begin
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy && !prev_busy) busy_rise_cyc = cyc;
         if (din_ready && first_lo_cyc < 0) first_lo_cyc = cyc;
         if (!CE_n) ce_low_cnt++;
         if (din_ready) rdy_cnt++;
         if (!WE_n) begin we_low_cnt++; we_len++; end
         if (!WE_n && !io_oe) viol++;
         if (io_oe && !OE_n) viol++;
         if (!CE_n && (UB_n || LB_n)) viol++;
         if (prev_we && !WE_n && (!prev_oe || addr != prev_addr || io_out != prev_io)) viol++;
         if (!prev_we && WE_n) begin
            if (!io_oe || CE_n) viol++;
            w.a = addr; w.d = io_out; w.len = we_len;
            mem[addr[3:0]] = (wr_q.size() == corrupt_idx) ? (io_out ^ 16'h0100) : io_out;
            wr_q.push_back(w);
            we_len = 0;
         end
      end else begin
         we_len = 0;
      end
      prev_we = WE_n; prev_oe = io_oe; prev_busy = busy; prev_addr = addr; prev_io = io_out;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic start_frame(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      wr_q.delete();
      first_lo_cyc = -1;
      base_addr = b; n_words = n; start_n = 1'b0;
      tick(1);
      start_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      din = b; din_valid = 1'b1;
      while (!din_ready && t < 100) begin tick(1); t++; end
      if (t >= 100) check_val("ready_timeout", 32'(t), 32'd0);
      tick(1);
      din_valid = 1'b0;
   endtask

   task automatic wait_done(input int base_cnt);
      int t = 0;
      while (done_cnt == base_cnt && t < 300) begin tick(1); t++; end
      if (t >= 300) check_val("done_timeout", 32'(t), 32'd0);
   endtask

   task automatic check_write(input string tag, input logic [ADDR_W-1:0] ea, input logic [15:0] ed);
      wr_t w;
      if (wr_q.size() == 0) begin
         check_val({tag, "_missing"}, 32'd0, 32'd1);
      end else begin
         w = wr_q.pop_front();
         check_val({tag, "_addr"}, 32'(w.a), 32'(ea));
         check_val({tag, "_data"}, 32'(w.d), 32'(ed));
         check_val({tag, "_we_len"}, 32'(w.len), 32'(WR_PULSE));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] t1_bytes [0:5];
   int d0, t;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      t1_bytes[0] = 8'h11; t1_bytes[1] = 8'h22; t1_bytes[2] = 8'h33;
      t1_bytes[3] = 8'h44; t1_bytes[4] = 8'h55; t1_bytes[5] = 8'h66;
      rst = 1'b1; start_n = 1'b1; base_addr = '0; n_words = '0; din = '0; din_valid = 1'b0;
      tick(3);
      check_val("rst_strobes", {27'd0, CE_n, OE_n, WE_n, UB_n, LB_n}, 32'h1F);
      check_val("rst_addr", 32'(addr), 32'd0);
      check_val("rst_io", {15'd0, io_oe, io_out}, 32'd0);
      check_val("rst_flags", {29'd0, din_ready, busy, done}, 32'd0);
      rst = 1'b0;
      tick(2);

      // 1: three words, stream always valid
      d0 = done_cnt;
      start_frame(20'h0, 20'd3);
      for (int i = 0; i < 6; i++) send_byte(t1_bytes[i]);
      wait_done(d0);
      tick(3);
      check_val("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
      check_val("t1_done_latency", 32'(done_cyc - first_lo_cyc), 32'(3 * WORD_CYC));
      check_val("t1_busy_after", {31'd0, busy}, 32'd0);
      check_write("t1_w0", 20'h0, 16'h2211);
      check_write("t1_w1", 20'h1, 16'h4433);
      check_write("t1_w2", 20'h2, 16'h6655);
`ifdef SRAM_WR_READBACK_EN
      check_val("t1_err_cnt", 32'(err_cnt), 32'd0);
`endif

      // 2: zero-length frame
      d0 = done_cnt; ce_low_cnt = 0; we_low_cnt = 0; rdy_cnt = 0;
      start_frame(20'h123, 20'd0);
      wait_done(d0);
      tick(3);
      check_val("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
      check_val("t2_done_vs_accept", 32'(done_cyc - busy_rise_cyc), 32'd0);
      check_val("t2_ce_low", 32'(ce_low_cnt), 32'd0);
      check_val("t2_we_low", 32'(we_low_cnt), 32'd0);
      check_val("t2_ready", 32'(rdy_cnt), 32'd0);

      // 3: address wrap
      d0 = done_cnt;
      start_frame(20'hFFFFF, 20'd2);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_done(d0);
      tick(2);
      check_write("t3_w0", 20'hFFFFF, 16'h0201);
      check_write("t3_w1", 20'h00000, 16'h0403);

      // 4: stream stalls between low and high byte
      d0 = done_cnt;
      start_frame(20'h40, 20'd1);
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check_val($sformatf("t4_gap%0d_ce_ready", i), {30'd0, CE_n, din_ready}, 32'h3);
      end
      check_val("t4_no_early_write", 32'(wr_q.size()), 32'd0);
      send_byte(8'h5A);
      wait_done(d0);
      tick(2);
      check_write("t4_w0", 20'h40, 16'h5AA5);

      // 5: reset in the middle of the WE_n pulse
      start_frame(20'h5, 20'd1);
      send_byte(8'h34); send_byte(8'h12);
      t = 0;
      while (WE_n && t < 20) begin tick(1); t++; end
      check_val("t5_reach_pulse", {31'd0, WE_n}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check_val("t5_rst_bus", {29'd0, WE_n, CE_n, io_oe}, 32'h6);
      check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
      tick(2);
      rst = 1'b0;
      tick(1);
      check_val("t5_aborted_logged", 32'(wr_q.size()), 32'd0);
      d0 = done_cnt;
      start_frame(20'h5, 20'd2);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'hBC); send_byte(8'h9A);
      wait_done(d0);
      tick(2);
      check_write("t5_w0", 20'h5, 16'h5678);
      check_write("t5_w1", 20'h6, 16'h9ABC);

`ifdef SRAM_WR_READBACK_EN
      // 6: memory corrupts the second word of three
      d0 = done_cnt;
      corrupt_idx = 1;
      start_frame(20'h0, 20'd3);
      for (int i = 0; i < 6; i++) send_byte(t1_bytes[i]);
      wait_done(d0);
      tick(3);
      corrupt_idx = -1;
      check_val("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
      check_val("t6_err_cnt", 32'(err_cnt), 32'd1);
      check_val("t6_err_addr", 32'(err_addr), 32'd1);
`endif

      check_val("bus_invariants", 32'(viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
